red_pipe_datapath: RTL and testbench
====================================

// Module: red_pipe_datapath
// PURPOSE
//  4-stage pipelined successor to the single-cycle register/ALU/data-memory datapath.
//  Stages: D (regfile read) -> E (ALU) -> M (data memory) -> W (writeback).
//  Full operand forwarding and a 1-cycle load-use stall. Parametrised register count and memory depth.
//  Sits between the decoder/PC unit, which supplies decoded control, and the branch logic (Zero).
// PARAMETERS
//  DATA_WIDTH     32  datapath and memory word width
//  ADDRESS_WIDTH  5   register index width; the regfile holds 2**ADDRESS_WIDTH registers
//  ALUctrl_WIDTH  3   ALU opcode width
//  DMEM_AW        8   data memory word-address width (2**DMEM_AW words)
//  A0_IDX         10  register index mirrored on output a0
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              asynchronous, active-high reset
//  in_valid   in   1              decoded instruction present on the inputs below
//  in_ready   out  1              D stage accepts the instruction this cycle
//  ImmOp      in   DATA_WIDTH     immediate operand
//  RegWrite   in   1              instruction writes rd
//  ALUctrl    in   ALUctrl_WIDTH  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt (signed), 110 sll, 111 srl
//  ALUsrc     in   1              1: ALU op2 = ImmOp; 0: ALU op2 = rs2 value
//  rs1,rs2,rd in   ADDRESS_WIDTH  source and destination register indices
//  MemWrite   in   1              store rs2 value at the ALU address
//  ResultSrc  in   2              00 ALU, 01 load data, 1x PCPlus4
//  PCPlus4    in   DATA_WIDTH     link value carried down the pipe
//  Zero       out  1              E-stage ALU result == 0, qualified by E valid
//  a0         out  DATA_WIDTH     register A0_IDX (registered, includes W-stage write)
//  wb_valid   out  1              retire strobe; 1 per instruction leaving W
//  wb_rd      out  ADDRESS_WIDTH  retired destination register
//  wb_data    out  DATA_WIDTH     retired writeback value
// BEHAVIOUR
//  - Reset (async): all stage valid bits 0; regfile 0; a0, wb_* and Zero 0. Data memory is not reset.
//  - Accept: D captures the inputs on clk when in_valid && in_ready.
//    If in_valid=0, a bubble enters the pipe. Latency from accept to wb_valid is 4 cycles.
//  - Register x0 always reads 0. Writes to x0 are dropped, but still retire with wb_rd=0 and wb_data=0.
//  - Regfile write happens in W at the clock edge. A D-stage read of the same register that W is writing
//    returns the new value (write-first).
//  - E operand forwarding, highest priority first:
//      1. M stage: valid, RegWrite, rd!=0, rd match; forward the ALU result, or PCPlus4 when ResultSrc[1].
//      2. W stage: valid, RegWrite, rd!=0, rd match; forward the writeback value.
//      3. Otherwise the D-captured register value.
//    Forwarding applies to rs1 and to rs2. The rs2 path feeds both the ALU (when ALUsrc=0) and the store data.
//  - Data memory: byte address = ALU result; word index = addr[DMEM_AW+1:2]; low 2 bits ignored.
//    Read is synchronous: the address is presented in M and the data is used in W.
//    The write happens at the M clock edge. An address beyond the depth wraps (upper bits ignored).
//  - Load-use hazard: E holds a load (ResultSrc=01, valid, rd!=0) and the D instruction reads that rd.
//    - in_ready=0 for exactly 1 cycle; D holds its contents; a bubble is inserted into E.
//    - After the load reaches W, the dependent instruction gets the load data through W forwarding.
//  - in_ready is combinational from pipe state only; it does not depend on in_valid.
//  - ALU arithmetic is mod 2**DATA_WIDTH. Shift amount = op2[$clog2(DATA_WIDTH)-1:0].
//    slt gives 1 or 0 in the LSB.
//  - Store plus load to the same word in consecutive instructions: the load returns the stored value.
//  - Reset mid-operation flushes every in-flight instruction: no retire and no regfile write.
//    A memory write already committed stays committed.
// TESTING
//  1. ALU chain: addi x1=5; addi x2=x1+3; sub x10=x2-x1, back-to-back
//     -> a0=3 five cycles after the last accept; no stalls.
//  2. Store/load: x3=0x40, x4=0xDEAD; sw x4,0(x3); lw x5,0(x3); add x10=x5+x0
//     -> one in_ready=0 cycle before the add; a0=0xDEAD.
//  3. x0 write: addi x0=7; add x10=x0+x0 -> wb_rd=0 and wb_data=0 retire; a0=0.
//  4. Forward priority: addi x6=1; addi x6=2; add x10=x6+x6 -> a0=4 (M value wins over W value).
//  5. Reset with 3 instructions in flight
//     -> wb_valid stays 0, regfile unchanged (0), in_ready=1 after rst drops.
//  6. Zero/wrap: sub x7=x1-x1 -> Zero=1 in its E cycle; sw to 0x400 with DMEM_AW=8 aliases word 0.

Source files
------------

// File: rtl/red_pipe_datapath_if.sv
// Instruction/retire bundle between the decoder/PC unit (master) and the pipelined datapath (slave).
//  master drives: in_valid, ImmOp, RegWrite, ALUctrl, ALUsrc, rs1, rs2, rd, MemWrite, ResultSrc, PCPlus4
//  master reads : in_ready, Zero, a0, wb_valid, wb_rd, wb_data
interface red_pipe_datapath_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned ALUctrl_WIDTH = 3
);
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_WIDTH-1:0]    ImmOp;
    logic                     RegWrite;
    logic [ALUctrl_WIDTH-1:0] ALUctrl;
    logic                     ALUsrc;
    logic [ADDRESS_WIDTH-1:0] rs1;
    logic [ADDRESS_WIDTH-1:0] rs2;
    logic [ADDRESS_WIDTH-1:0] rd;
    logic                     MemWrite;
    logic [1:0]               ResultSrc;
    logic [DATA_WIDTH-1:0]    PCPlus4;
    logic                     Zero;
    logic [DATA_WIDTH-1:0]    a0;
    logic                     wb_valid;
    logic [ADDRESS_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0]    wb_data;

    modport master (
        output in_valid, ImmOp, RegWrite, ALUctrl, ALUsrc, rs1, rs2, rd, MemWrite, ResultSrc, PCPlus4,
        input  in_ready, Zero, a0, wb_valid, wb_rd, wb_data
    );

    modport slave (
        input  in_valid, ImmOp, RegWrite, ALUctrl, ALUsrc, rs1, rs2, rd, MemWrite, ResultSrc, PCPlus4,
        output in_ready, Zero, a0, wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/red_pipe_datapath.sv
// 4-stage pipelined register/ALU/data-memory datapath: D (regfile read) -> E (ALU) ->
// M (data memory) -> W (writeback), with M/W operand forwarding and a 1-cycle load-use stall.
//  clk, rst : rising-edge clock, asynchronous active-high reset
//  bus      : slave side of red_pipe_datapath_if (decoded instruction in, in_ready/Zero/a0/retire out)
module red_pipe_datapath #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned ALUctrl_WIDTH = 3,
    parameter int unsigned DMEM_AW       = 8,
    parameter int unsigned A0_IDX        = 10
) (
    input logic                clk,
    input logic                rst,
    red_pipe_datapath_if.slave bus
);
    localparam int unsigned NREGS = 2 ** ADDRESS_WIDTH;
    localparam int unsigned SHW   = $clog2(DATA_WIDTH);

    typedef logic [DATA_WIDTH-1:0]    word_t;
    typedef logic [ADDRESS_WIDTH-1:0] ridx_t;
    typedef logic [ALUctrl_WIDTH-1:0] aluc_t;

    localparam ridx_t A0_REG = ridx_t'(A0_IDX);

    word_t regs [NREGS];
    word_t mem  [2 ** DMEM_AW];

    // D stage
    logic  d_valid, d_rw, d_src, d_mw;
    aluc_t d_aluc;
    ridx_t d_rs1, d_rs2, d_rd;
    logic [1:0] d_rsrc;
    word_t d_imm, d_pc4, d_rv1, d_rv2;
    // E stage
    logic  e_valid, e_rw, e_src, e_mw;
    aluc_t e_aluc;
    ridx_t e_rs1, e_rs2, e_rd;
    logic [1:0] e_rsrc;
    word_t e_imm, e_pc4, e_rv1, e_rv2;
    // M stage
    logic  m_valid, m_rw, m_mw;
    ridx_t m_rd;
    logic [1:0] m_rsrc;
    word_t m_pc4, m_alu, m_sd;
    // W stage
    logic  w_valid, w_rw;
    ridx_t w_rd;
    logic [1:0] w_rsrc;
    word_t w_pc4, w_alu, w_mem;
    // retire / mirror
    logic  wb_valid_q;
    ridx_t wb_rd_q;
    word_t wb_data_q, a0_q;

    logic  in_ready, d_reads_rs2, w_wen, m_fwd_en1, m_fwd_en2, w_fwd_en1, w_fwd_en2;
    word_t w_res, m_fwd, op1, op2, fwd2, alu_res;
    logic [DMEM_AW-1:0] m_idx;

    assign w_wen = w_valid && w_rw && (w_rd != '0);
    assign w_res = w_rsrc[1] ? w_pc4 : (w_rsrc[0] ? w_mem : w_alu);

    // Only instructions that actually consume rs2 (register op2 or store data) can stall on it.
    assign d_reads_rs2 = !d_src || d_mw;
    assign in_ready = !(e_valid && (e_rsrc == 2'b01) && (e_rd != '0) && d_valid &&
                        ((d_rs1 == e_rd) || (d_reads_rs2 && (d_rs2 == e_rd))));

    // Regfile read with write-first bypass of the W-stage write landing this edge.
    always_comb begin
        d_rv1 = regs[d_rs1];
        d_rv2 = regs[d_rs2];
        if (w_wen && (w_rd == d_rs1)) d_rv1 = w_res;
        if (w_wen && (w_rd == d_rs2)) d_rv2 = w_res;
        if (d_rs1 == '0) d_rv1 = '0;
        if (d_rs2 == '0) d_rv2 = '0;
    end

    assign m_fwd     = m_rsrc[1] ? m_pc4 : m_alu;
    assign m_fwd_en1 = m_valid && m_rw && (m_rd != '0) && (m_rd == e_rs1);
    assign m_fwd_en2 = m_valid && m_rw && (m_rd != '0) && (m_rd == e_rs2);
    assign w_fwd_en1 = w_wen && (w_rd == e_rs1);
    assign w_fwd_en2 = w_wen && (w_rd == e_rs2);

    always_comb begin
        op1 = e_rv1;
        if (m_fwd_en1)      op1 = m_fwd;
        else if (w_fwd_en1) op1 = w_res;
        fwd2 = e_rv2;
        if (m_fwd_en2)      fwd2 = m_fwd;
        else if (w_fwd_en2) fwd2 = w_res;
        op2 = e_src ? e_imm : fwd2;
    end

    always_comb begin
        alu_res = '0;
        case (e_aluc)
            aluc_t'(3'b000): alu_res = op1 + op2;
            aluc_t'(3'b001): alu_res = op1 - op2;
            aluc_t'(3'b010): alu_res = op1 & op2;
            aluc_t'(3'b011): alu_res = op1 | op2;
            aluc_t'(3'b100): alu_res = op1 ^ op2;
            aluc_t'(3'b101): alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            aluc_t'(3'b110): alu_res = op1 << op2[SHW-1:0];
            aluc_t'(3'b111): alu_res = op1 >> op2[SHW-1:0];
            default:         alu_res = '0;
        endcase
    end

    // Word index drops the byte offset; upper address bits alias.
    assign m_idx = m_alu[DMEM_AW+1:2];

    always_ff @(posedge clk) begin
        if (m_valid && m_mw) mem[m_idx] <= m_sd;
        w_mem <= mem[m_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_valid <= 1'b0; d_rw <= 1'b0; d_src <= 1'b0; d_mw <= 1'b0; d_aluc <= '0;
            d_rs1 <= '0; d_rs2 <= '0; d_rd <= '0; d_rsrc <= '0; d_imm <= '0; d_pc4 <= '0;
            e_valid <= 1'b0; e_rw <= 1'b0; e_src <= 1'b0; e_mw <= 1'b0; e_aluc <= '0;
            e_rs1 <= '0; e_rs2 <= '0; e_rd <= '0; e_rsrc <= '0; e_imm <= '0; e_pc4 <= '0;
            e_rv1 <= '0; e_rv2 <= '0;
            m_valid <= 1'b0; m_rw <= 1'b0; m_mw <= 1'b0; m_rd <= '0; m_rsrc <= '0;
            m_pc4 <= '0; m_alu <= '0; m_sd <= '0;
            w_valid <= 1'b0; w_rw <= 1'b0; w_rd <= '0; w_rsrc <= '0; w_pc4 <= '0; w_alu <= '0;
            wb_valid_q <= 1'b0; wb_rd_q <= '0; wb_data_q <= '0; a0_q <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            // On a stall D holds and E takes a bubble.
            if (in_ready) begin
                d_valid <= bus.in_valid;
                d_rw    <= bus.RegWrite;
                d_src   <= bus.ALUsrc;
                d_mw    <= bus.MemWrite;
                d_aluc  <= bus.ALUctrl;
                d_rs1   <= bus.rs1;
                d_rs2   <= bus.rs2;
                d_rd    <= bus.rd;
                d_rsrc  <= bus.ResultSrc;
                d_imm   <= bus.ImmOp;
                d_pc4   <= bus.PCPlus4;
            end
            e_valid <= d_valid && in_ready;
            e_rw    <= d_rw;   e_src <= d_src;  e_mw  <= d_mw;   e_aluc <= d_aluc;
            e_rs1   <= d_rs1;  e_rs2 <= d_rs2;  e_rd  <= d_rd;   e_rsrc <= d_rsrc;
            e_imm   <= d_imm;  e_pc4 <= d_pc4;  e_rv1 <= d_rv1;  e_rv2  <= d_rv2;

            m_valid <= e_valid; m_rw <= e_rw; m_mw <= e_mw; m_rd <= e_rd; m_rsrc <= e_rsrc;
            m_pc4   <= e_pc4;   m_alu <= alu_res; m_sd <= fwd2;

            w_valid <= m_valid; w_rw <= m_rw; w_rd <= m_rd; w_rsrc <= m_rsrc;
            w_pc4   <= m_pc4;   w_alu <= m_alu;

            wb_valid_q <= w_valid;
            wb_rd_q    <= w_rd;
            wb_data_q  <= w_wen ? w_res : '0;
            if (w_wen) regs[w_rd] <= w_res;
            if (w_wen && (w_rd == A0_REG)) a0_q <= w_res;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.Zero     = e_valid && (alu_res == '0);
    assign bus.a0       = a0_q;
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_rd    = wb_rd_q;
    assign bus.wb_data  = wb_data_q;
endmodule

// File: tb/tb_red_pipe_datapath.sv
// Randomized + directed bench for red_pipe_datapath against an instruction-at-a-time reference model.
module tb_red_pipe_datapath;
    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    red_pipe_datapath_if bus ();

    red_pipe_datapath dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  aluc;
        logic        src;
        logic        rw;
        logic        mw;
        logic [1:0]  rsrc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc4;
    } instr_t;

    // Reference state: architectural registers, memory words, expected retire stream.
    logic [31:0] mref [32];
    logic [31:0] mem_ref [int];
    logic [36:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic instr_t op_r(input logic [2:0] c, input logic [4:0] rd, rs1, rs2);
        return '{aluc: c, src: 1'b0, rw: 1'b1, mw: 1'b0, rsrc: 2'b00,
                 rs1: rs1, rs2: rs2, rd: rd, imm: 32'h0, pc4: 32'h0};
    endfunction
    function automatic instr_t op_i(input logic [2:0] c, input logic [4:0] rd, rs1,
                                    input logic [31:0] imm);
        return '{aluc: c, src: 1'b1, rw: 1'b1, mw: 1'b0, rsrc: 2'b00,
                 rs1: rs1, rs2: 5'd0, rd: rd, imm: imm, pc4: 32'h0};
    endfunction
    function automatic instr_t op_lw(input logic [4:0] rd, rs1, input logic [31:0] imm);
        return '{aluc: 3'b000, src: 1'b1, rw: 1'b1, mw: 1'b0, rsrc: 2'b01,
                 rs1: rs1, rs2: 5'd0, rd: rd, imm: imm, pc4: 32'h0};
    endfunction
    function automatic instr_t op_sw(input logic [4:0] rs2, rs1, input logic [31:0] imm);
        return '{aluc: 3'b000, src: 1'b1, rw: 1'b0, mw: 1'b1, rsrc: 2'b00,
                 rs1: rs1, rs2: rs2, rd: 5'd0, imm: imm, pc4: 32'h0};
    endfunction
    function automatic instr_t op_link(input logic [4:0] rd, input logic [31:0] pc4);
        return '{aluc: 3'b000, src: 1'b1, rw: 1'b1, mw: 1'b0, rsrc: 2'b10,
                 rs1: 5'd0, rs2: 5'd0, rd: rd, imm: 32'h0, pc4: pc4};
    endfunction

    function automatic logic [31:0] alu_ref(input logic [2:0] c, input logic [31:0] a, b);
        case (c)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: return a << (b % 32);
            default: return a >> (b % 32);
        endcase
    endfunction

    // Executes one instruction to completion in program order.
    task automatic model_exec(input instr_t i);
        logic [31:0] a, sd, r, res;
        int idx;
        a   = mref[i.rs1];
        sd  = mref[i.rs2];
        r   = alu_ref(i.aluc, a, i.src ? i.imm : sd);
        idx = int'((r / 4) % 256);
        if (i.mw) mem_ref[idx] = sd;
        if (i.rsrc[1])      res = i.pc4;
        else if (i.rsrc[0]) res = mem_ref.exists(idx) ? mem_ref[idx] : 32'hxxxx_xxxx;
        else                res = r;
        if (i.rw && i.rd != 0) begin
            mref[i.rd] = res;
            exp_q.push_back({i.rd, res});
        end else begin
            exp_q.push_back({i.rd, 32'h0});
        end
    endtask

    task automatic send(input instr_t i, output int stalls);
        stalls = 0;
        bus.ALUctrl   = i.aluc;
        bus.ALUsrc    = i.src;
        bus.RegWrite  = i.rw;
        bus.MemWrite  = i.mw;
        bus.ResultSrc = i.rsrc;
        bus.rs1       = i.rs1;
        bus.rs2       = i.rs2;
        bus.rd        = i.rd;
        bus.ImmOp     = i.imm;
        bus.PCPlus4   = i.pc4;
        bus.in_valid  = 1'b1;
        while (!bus.in_ready && stalls < 8) begin
            @(posedge clk); #1;
            stalls++;
        end
        check("accept_ready", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        model_exec(i);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        bus.in_valid = 1'b0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Retire monitor: every wb_valid pulse is matched in order against the model.
    always @(negedge clk) begin
        logic [36:0] e;
        if (bus.wb_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_retire", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wb_rd", {27'b0, bus.wb_rd}, {27'b0, e[36:32]});
                check("wb_data", bus.wb_data, e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end, got timeout required finish");
        $fatal(1);
    end

    initial begin
        int st, tot;
        instr_t ins;
        logic [31:0] addr;

        rst = 1'b0;
        bus.in_valid = 1'b0; bus.ImmOp = '0; bus.RegWrite = 1'b0; bus.ALUctrl = '0;
        bus.ALUsrc = 1'b0; bus.rs1 = '0; bus.rs2 = '0; bus.rd = '0; bus.MemWrite = 1'b0;
        bus.ResultSrc = '0; bus.PCPlus4 = '0;
        for (int i = 0; i < 32; i++) mref[i] = 32'h0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("rst_wb_valid", {31'b0, bus.wb_valid}, 32'd0);
        check("rst_wb_data", bus.wb_data, 32'd0);
        check("rst_a0", bus.a0, 32'd0);
        check("rst_zero", {31'b0, bus.Zero}, 32'd0);
        rst = 1'b0;
        idle(1);

        // 1: back-to-back dependent ALU chain, no stalls
        tot = 0;
        send(op_i(3'd0, 5'd1, 5'd0, 32'd5), st);  tot += st;
        send(op_i(3'd0, 5'd2, 5'd1, 32'd3), st);  tot += st;
        send(op_r(3'd1, 5'd10, 5'd2, 5'd1), st);  tot += st;
        check("chain_stalls", tot, 0);
        idle(5);
        check("chain_a0", bus.a0, 32'd3);
        drain();

        // 2: store then load-use, one stall cycle after the dependent add enters D
        send(op_i(3'd0, 5'd3, 5'd0, 32'h40), st);
        send(op_i(3'd0, 5'd4, 5'd0, 32'hDEAD), st);
        send(op_sw(5'd4, 5'd3, 32'd0), st);
        send(op_lw(5'd5, 5'd3, 32'd0), st);
        check("lw_stalls", st, 0);
        send(op_r(3'd0, 5'd10, 5'd5, 5'd0), st);
        check("ldu_in_ready", {31'b0, bus.in_ready}, 32'd0);
        send(op_i(3'd0, 5'd0, 5'd0, 32'd0), st);
        check("ldu_stalls", st, 1);
        drain();
        check("ldu_a0", bus.a0, 32'hDEAD);

        // 3: x0 writes are dropped but retire as rd=0/data=0
        send(op_i(3'd0, 5'd0, 5'd0, 32'd7), st);
        send(op_r(3'd0, 5'd10, 5'd0, 5'd0), st);
        drain();
        check("x0_a0", bus.a0, 32'd0);

        // 4: M-stage value wins over W-stage value for the same rd
        send(op_i(3'd0, 5'd6, 5'd0, 32'd1), st);
        send(op_i(3'd0, 5'd6, 5'd0, 32'd2), st);
        send(op_r(3'd0, 5'd10, 5'd6, 5'd6), st);
        drain();
        check("fwd_prio_a0", bus.a0, 32'd4);

        // 5: reset flushes three in-flight instructions and clears the regfile
        send(op_i(3'd0, 5'd11, 5'd0, 32'd1), st);
        send(op_i(3'd0, 5'd12, 5'd0, 32'd2), st);
        send(op_i(3'd0, 5'd10, 5'd0, 32'd3), st);
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 32; i++) mref[i] = 32'h0;
        idle(2);
        check("flush_wb_valid_rst", {31'b0, bus.wb_valid}, 32'd0);
        rst = 1'b0;
        check("flush_in_ready", {31'b0, bus.in_ready}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            check("flush_wb_valid", {31'b0, bus.wb_valid}, 32'd0);
        end
        check("flush_a0", bus.a0, 32'd0);
        send(op_r(3'd0, 5'd10, 5'd11, 5'd12), st);
        drain();
        check("flush_regs_a0", bus.a0, 32'd0);

        // 6: Zero in E, then address wrap aliasing word 0
        send(op_i(3'd0, 5'd1, 5'd0, 32'd77), st);
        send(op_r(3'd1, 5'd7, 5'd1, 5'd1), st);
        idle(1);
        check("zero_in_e", {31'b0, bus.Zero}, 32'd1);
        idle(1);
        check("zero_bubble", {31'b0, bus.Zero}, 32'd0);
        send(op_i(3'd0, 5'd8, 5'd0, 32'h400), st);
        send(op_i(3'd0, 5'd9, 5'd0, 32'h1234), st);
        send(op_sw(5'd9, 5'd8, 32'd0), st);
        send(op_lw(5'd10, 5'd0, 32'd0), st);
        drain();
        check("wrap_a0", bus.a0, 32'h1234);

        // Accept-to-retire latency of an isolated instruction
        send(op_i(3'd0, 5'd13, 5'd0, 32'd9), st);
        idle(3);
        check("lat_early", {31'b0, bus.wb_valid}, 32'd0);
        idle(1);
        check("lat_retire", {31'b0, bus.wb_valid}, 32'd1);
        drain();

        // Randomized mix over a small register set to provoke hazards
        for (int w = 0; w < 8; w++) send(op_sw(5'd0, 5'd0, 32'(w * 4)), st);
        for (int n = 0; n < 250; n++) begin
            addr = ($urandom_range(0, 1) != 0 ? 32'h400 : 32'h0) + 32'($urandom_range(0, 7) * 4)
                   + 32'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0, 1, 2, 3: ins = op_r(3'($urandom_range(0, 7)), 5'($urandom_range(0, 11)),
                                       5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)));
                4, 5:       ins = op_i(3'($urandom_range(0, 7)), 5'($urandom_range(0, 11)),
                                       5'($urandom_range(0, 11)), $urandom);
                6, 7:       ins = op_lw(5'($urandom_range(0, 11)), 5'd0, addr);
                8:          ins = op_sw(5'($urandom_range(0, 11)), 5'd0, addr);
                default:    ins = op_link(5'($urandom_range(0, 11)), $urandom);
            endcase
            send(ins, st);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        drain();
        check("rand_a0", bus.a0, mref[10]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
